// File: rtl/spectrum_frame_sequencer.sv
// spectrum_frame_sequencer
// Sequences one FFT run: sends the config word, cuts the sample stream into
// 2^log2n frames with a generated tlast, then scans the result stream for the
// largest-magnitude bin. Continuous mode repeats frames until a stop arrives.
module spectrum_frame_sequencer #(
    parameter int DATA_W    = 16,
    parameter int MAX_LOG2N = 10,
    parameter int CFG_W     = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  ctrl_start,
    input  logic                  ctrl_stop,
    input  logic                  ctrl_continuous,
    input  logic [3:0]            ctrl_log2n,
    input  logic                  ctrl_fwd_inv,
    input  logic [2*DATA_W-1:0]   s_axis_samp_tdata,
    input  logic                  s_axis_samp_tvalid,
    output logic                  s_axis_samp_tready,
    output logic [2*DATA_W-1:0]   m_axis_fft_tdata,
    output logic                  m_axis_fft_tvalid,
    input  logic                  m_axis_fft_tready,
    output logic                  m_axis_fft_tlast,
    output logic [CFG_W-1:0]      m_axis_cfg_tdata,
    output logic                  m_axis_cfg_tvalid,
    input  logic                  m_axis_cfg_tready,
    input  logic [2*DATA_W-1:0]   s_axis_res_tdata,
    input  logic                  s_axis_res_tvalid,
    input  logic                  s_axis_res_tlast,
    output logic                  s_axis_res_tready,
    output logic [MAX_LOG2N-1:0]  peak_bin,
    output logic [DATA_W:0]       peak_mag,
    output logic                  frame_done,
    output logic [15:0]           frame_count,
    output logic                  busy,
    output logic                  err_tlast
);

    localparam int CNT_W = MAX_LOG2N;
    localparam logic [CNT_W:0]  LEN_ONE = 1;
    localparam logic [DATA_W:0] MAG_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [4:0]         log2n_q;
    logic [4:0]         log2n_clamped;
    logic               fwd_inv_q;
    logic               continuous_q;
    logic               stop_pending;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   bin_cnt;
    logic [CNT_W-1:0]   last_idx;
    logic [CNT_W-1:0]   max_bin;
    logic [CNT_W-1:0]   best_bin;
    logic [CNT_W:0]     frame_len;
    logic [DATA_W:0]    max_mag;
    logic [DATA_W:0]    best_mag;
    logic [DATA_W:0]    cur_mag;
    logic [DATA_W:0]    re_ext;
    logic [DATA_W:0]    im_ext;
    logic [DATA_W:0]    abs_re;
    logic [DATA_W:0]    abs_im;
    logic [CFG_W-1:0]   cfg_word;
    logic               start_ok;
    logic               samp_fire;
    logic               res_fire;
    logic               res_end;
    logic               last_beat;

    assign frame_len = LEN_ONE << log2n_q;
    assign last_idx  = CNT_W'(frame_len - LEN_ONE);
    assign start_ok  = (state == S_IDLE) && ctrl_start && !ctrl_stop;
    assign samp_fire = (state == S_CAPTURE) && s_axis_samp_tvalid && m_axis_fft_tready;
    assign last_beat = (beat_cnt == last_idx);
    assign res_fire  = (state == S_DRAIN) && s_axis_res_tvalid;
    assign res_end   = res_fire && (s_axis_res_tlast || (bin_cnt == last_idx));
    assign busy      = (state != S_IDLE);

    // Clamp the requested frame size exponent into the supported range
    always_comb begin
        log2n_clamped = {1'b0, ctrl_log2n};
        if (log2n_clamped < 5'd3) begin
            log2n_clamped = 5'd3;
        end else if (log2n_clamped > 5'(MAX_LOG2N)) begin
            log2n_clamped = 5'(MAX_LOG2N);
        end
    end

    // Config word: size exponent in the low bits, direction flag at bit 8
    always_comb begin
        cfg_word      = '0;
        cfg_word[4:0] = log2n_q;
        cfg_word[8]   = fwd_inv_q;
    end

    // |re| + |im| of the current result beat and the running max including it
    always_comb begin
        re_ext   = {s_axis_res_tdata[DATA_W-1], s_axis_res_tdata[DATA_W-1:0]};
        im_ext   = {s_axis_res_tdata[2*DATA_W-1], s_axis_res_tdata[2*DATA_W-1:DATA_W]};
        abs_re   = re_ext[DATA_W] ? (~re_ext + MAG_ONE) : re_ext;
        abs_im   = im_ext[DATA_W] ? (~im_ext + MAG_ONE) : im_ext;
        cur_mag  = abs_re + abs_im;
        best_mag = max_mag;
        best_bin = max_bin;
        if ((bin_cnt == '0) || (cur_mag > max_mag)) begin
            best_mag = cur_mag;
            best_bin = bin_cnt;
        end
    end

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and stream handshake steering
    always_comb begin
        next_state         = state;
        m_axis_cfg_tvalid  = 1'b0;
        m_axis_cfg_tdata   = '0;
        m_axis_fft_tvalid  = 1'b0;
        m_axis_fft_tdata   = '0;
        m_axis_fft_tlast   = 1'b0;
        s_axis_samp_tready = 1'b0;
        s_axis_res_tready  = 1'b0;
        frame_done         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) next_state = S_CONFIG;
            end
            S_CONFIG: begin
                m_axis_cfg_tvalid = 1'b1;
                m_axis_cfg_tdata  = cfg_word;
                if (m_axis_cfg_tready) next_state = S_CAPTURE;
            end
            S_CAPTURE: begin
                m_axis_fft_tvalid  = s_axis_samp_tvalid;
                m_axis_fft_tdata   = s_axis_samp_tdata;
                m_axis_fft_tlast   = last_beat;
                s_axis_samp_tready = m_axis_fft_tready;
                if (samp_fire && last_beat) next_state = S_DRAIN;
            end
            S_DRAIN: begin
                s_axis_res_tready = 1'b1;
                if (res_end) next_state = S_DONE;
            end
            S_DONE: begin
                frame_done = 1'b1;
                if (continuous_q && !stop_pending && !ctrl_stop) begin
                    next_state = S_CAPTURE;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Latch run parameters when a start is accepted
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            log2n_q      <= '0;
            fwd_inv_q    <= 1'b0;
            continuous_q <= 1'b0;
        end else if (start_ok) begin
            log2n_q      <= log2n_clamped;
            fwd_inv_q    <= ctrl_fwd_inv;
            continuous_q <= ctrl_continuous;
        end
    end

    // Sticky stop request and tlast error flag, both cleared by a new start
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stop_pending <= 1'b0;
            err_tlast    <= 1'b0;
        end else if (start_ok) begin
            stop_pending <= 1'b0;
            err_tlast    <= 1'b0;
        end else begin
            if (ctrl_stop && (state != S_IDLE)) stop_pending <= 1'b1;
            if (res_end && (s_axis_res_tlast != (bin_cnt == last_idx))) err_tlast <= 1'b1;
        end
    end

    // Beat and bin counters plus running peak tracker
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt <= '0;
            bin_cnt  <= '0;
            max_mag  <= '0;
            max_bin  <= '0;
        end else begin
            if (state != S_CAPTURE) begin
                beat_cnt <= '0;
            end else if (samp_fire) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state != S_DRAIN) begin
                bin_cnt <= '0;
            end else if (res_fire) begin
                bin_cnt <= bin_cnt + 1'b1;
                max_mag <= best_mag;
                max_bin <= best_bin;
            end
        end
    end

    // Publish the frame result on entry to DONE
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            peak_bin    <= '0;
            peak_mag    <= '0;
            frame_count <= '0;
        end else if (res_end) begin
            peak_bin    <= best_bin;
            peak_mag    <= best_mag;
            frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_spectrum_frame_sequencer.sv
// tb_spectrum_frame_sequencer
// Directed bench for the FFT frame sequencer: config word, framing and tlast,
// backpressure pass-through, peak search, continuous/stop, tlast errors, reset.
module tb_spectrum_frame_sequencer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        ctrl_start;
    logic        ctrl_stop;
    logic        ctrl_continuous;
    logic [3:0]  ctrl_log2n;
    logic        ctrl_fwd_inv;
    logic [31:0] s_axis_samp_tdata;
    logic        s_axis_samp_tvalid;
    logic        s_axis_samp_tready;
    logic [31:0] m_axis_fft_tdata;
    logic        m_axis_fft_tvalid;
    logic        m_axis_fft_tready;
    logic        m_axis_fft_tlast;
    logic [15:0] m_axis_cfg_tdata;
    logic        m_axis_cfg_tvalid;
    logic        m_axis_cfg_tready;
    logic [31:0] s_axis_res_tdata;
    logic        s_axis_res_tvalid;
    logic        s_axis_res_tlast;
    logic        s_axis_res_tready;
    logic [9:0]  peak_bin;
    logic [16:0] peak_mag;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        busy;
    logic        err_tlast;

    int          checks_total = 0;
    int          checks_passed = 0;
    int          cfg_xfers = 0;
    int          done_pulses = 0;
    int          cfg_base;
    int          done_base;
    int          forwarded;
    int          cyc;
    logic        rnd_valid;
    logic        rnd_ready;
    logic [31:0] res_vec [0:15];

    spectrum_frame_sequencer dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .ctrl_start         (ctrl_start),
        .ctrl_stop          (ctrl_stop),
        .ctrl_continuous    (ctrl_continuous),
        .ctrl_log2n         (ctrl_log2n),
        .ctrl_fwd_inv       (ctrl_fwd_inv),
        .s_axis_samp_tdata  (s_axis_samp_tdata),
        .s_axis_samp_tvalid (s_axis_samp_tvalid),
        .s_axis_samp_tready (s_axis_samp_tready),
        .m_axis_fft_tdata   (m_axis_fft_tdata),
        .m_axis_fft_tvalid  (m_axis_fft_tvalid),
        .m_axis_fft_tready  (m_axis_fft_tready),
        .m_axis_fft_tlast   (m_axis_fft_tlast),
        .m_axis_cfg_tdata   (m_axis_cfg_tdata),
        .m_axis_cfg_tvalid  (m_axis_cfg_tvalid),
        .m_axis_cfg_tready  (m_axis_cfg_tready),
        .s_axis_res_tdata   (s_axis_res_tdata),
        .s_axis_res_tvalid  (s_axis_res_tvalid),
        .s_axis_res_tlast   (s_axis_res_tlast),
        .s_axis_res_tready  (s_axis_res_tready),
        .peak_bin           (peak_bin),
        .peak_mag           (peak_mag),
        .frame_done         (frame_done),
        .frame_count        (frame_count),
        .busy               (busy),
        .err_tlast          (err_tlast)
    );

    // Free-running clock, 10 time units per cycle
    always #5 aclk = ~aclk;

    // Count config handshakes and frame_done pulses seen on the bus
    always @(posedge aclk) begin
        if (m_axis_cfg_tvalid && m_axis_cfg_tready) cfg_xfers <= cfg_xfers + 1;
        if (frame_done) done_pulses <= done_pulses + 1;
    end

    function automatic logic [31:0] sampVal(input int b);
        return 32'hC0DE_0000 + 32'(b);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic clearInputs();
        ctrl_start         = 1'b0;
        ctrl_stop          = 1'b0;
        ctrl_continuous    = 1'b0;
        ctrl_log2n         = 4'd0;
        ctrl_fwd_inv       = 1'b0;
        s_axis_samp_tdata  = '0;
        s_axis_samp_tvalid = 1'b0;
        m_axis_fft_tready  = 1'b0;
        m_axis_cfg_tready  = 1'b0;
        s_axis_res_tdata   = '0;
        s_axis_res_tvalid  = 1'b0;
        s_axis_res_tlast   = 1'b0;
    endtask

    task automatic doReset();
        aresetn = 1'b0;
        clearInputs();
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 16; i++) res_vec[i] = '0;
    endtask

    // Pulse start for one cycle; returns at the negedge of the CONFIG cycle
    task automatic applyStimulus(input logic [3:0] log2n, input logic fwd, input logic cont);
        ctrl_start      = 1'b1;
        ctrl_log2n      = log2n;
        ctrl_fwd_inv    = fwd;
        ctrl_continuous = cont;
        @(negedge aclk);
        ctrl_start = 1'b0;
    endtask

    task automatic acceptCfg();
        m_axis_cfg_tready = 1'b1;
        @(negedge aclk);
        m_axis_cfg_tready = 1'b0;
    endtask

    // Offer n samples at full rate, checking pass-through data and tlast
    task automatic driveSamples(input int n, input int stop_beat);
        int acc;
        int c;
        acc = 0;
        c = 0;
        while (acc < n && c < 4 * n + 20) begin
            s_axis_samp_tvalid = 1'b1;
            s_axis_samp_tdata  = sampVal(acc);
            m_axis_fft_tready  = 1'b1;
            ctrl_stop          = (acc == stop_beat);
            #1;
            if (s_axis_samp_tready) begin
                checkOutput("fft_tlast", 32'(m_axis_fft_tlast), 32'(acc == n - 1));
                checkOutput("fft_tdata", m_axis_fft_tdata, sampVal(acc));
                acc++;
            end
            c++;
            @(negedge aclk);
        end
        s_axis_samp_tvalid = 1'b0;
        m_axis_fft_tready  = 1'b0;
        ctrl_stop          = 1'b0;
        checkOutput("samp_beats", 32'(acc), 32'(n));
    endtask

    // Feed results from res_vec with tlast on tlast_beat; returns in DONE
    task automatic driveResults(input int n, input int tlast_beat);
        int acc;
        int c;
        int exp_beats;
        logic fin;
        acc = 0;
        c = 0;
        fin = 1'b0;
        exp_beats = (tlast_beat < n) ? tlast_beat + 1 : n;
        while (!fin && c < 4 * n + 20) begin
            s_axis_res_tvalid = 1'b1;
            s_axis_res_tdata  = res_vec[acc];
            s_axis_res_tlast  = (acc == tlast_beat);
            #1;
            if (s_axis_res_tready) begin
                if (s_axis_res_tlast || acc == n - 1) fin = 1'b1;
                acc++;
            end
            c++;
            @(negedge aclk);
        end
        s_axis_res_tvalid = 1'b0;
        s_axis_res_tlast  = 1'b0;
        checkOutput("res_beats", 32'(acc), 32'(exp_beats));
    endtask

    initial begin
        aresetn = 1'b0;
        clearInputs();
        for (int i = 0; i < 16; i++) res_vec[i] = '0;
        @(negedge aclk);
        #1;
        // Reset values
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_cfg_tvalid", 32'(m_axis_cfg_tvalid), 32'd0);
        checkOutput("rst_cfg_tdata", 32'(m_axis_cfg_tdata), 32'd0);
        checkOutput("rst_samp_tready", 32'(s_axis_samp_tready), 32'd0);
        checkOutput("rst_fft_tvalid", 32'(m_axis_fft_tvalid), 32'd0);
        checkOutput("rst_fft_tlast", 32'(m_axis_fft_tlast), 32'd0);
        checkOutput("rst_res_tready", 32'(s_axis_res_tready), 32'd0);
        checkOutput("rst_peak_bin", 32'(peak_bin), 32'd0);
        checkOutput("rst_peak_mag", 32'(peak_mag), 32'd0);
        checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
        checkOutput("rst_err", 32'(err_tlast), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        // Single shot, log2n=3, forward: bin 5 = (100, -50) is the peak
        $display("[TB] single shot log2n=3");
        for (int i = 0; i < 8; i++) res_vec[i] = {16'h0000, 16'(i)};
        res_vec[5] = {16'hFFCE, 16'h0064};
        applyStimulus(4'd3, 1'b1, 1'b0);
        s_axis_samp_tvalid = 1'b1;
        #1;
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_cfg_tvalid", 32'(m_axis_cfg_tvalid), 32'd1);
        checkOutput("t1_cfg_tdata", 32'(m_axis_cfg_tdata), 32'h0103);
        checkOutput("t1_samp_blocked", 32'(s_axis_samp_tready), 32'd0);
        @(negedge aclk);
        s_axis_samp_tvalid = 1'b0;
        #1;
        checkOutput("t1_cfg_hold", 32'(m_axis_cfg_tdata), 32'h0103);
        acceptCfg();
        #1;
        checkOutput("t1_cfg_dropped", 32'(m_axis_cfg_tvalid), 32'd0);
        driveSamples(8, -1);
        #1;
        checkOutput("t1_drain_res_tready", 32'(s_axis_res_tready), 32'd1);
        checkOutput("t1_drain_samp_tready", 32'(s_axis_samp_tready), 32'd0);
        driveResults(8, 7);
        #1;
        checkOutput("t1_frame_done", 32'(frame_done), 32'd1);
        checkOutput("t1_peak_bin", 32'(peak_bin), 32'd5);
        checkOutput("t1_peak_mag", 32'(peak_mag), 32'd150);
        checkOutput("t1_frame_count", 32'(frame_count), 32'd1);
        checkOutput("t1_err", 32'(err_tlast), 32'd0);
        @(negedge aclk);
        #1;
        checkOutput("t1_idle_busy", 32'(busy), 32'd0);
        checkOutput("t1_done_gone", 32'(frame_done), 32'd0);
        checkOutput("t1_peak_kept", 32'(peak_bin), 32'd5);

        // Backpressure on both sides of the capture path, log2n=4
        $display("[TB] backpressure log2n=4");
        doReset();
        applyStimulus(4'd4, 1'b0, 1'b0);
        #1;
        checkOutput("t2_cfg_tdata", 32'(m_axis_cfg_tdata), 32'h0004);
        acceptCfg();
        forwarded = 0;
        cyc = 0;
        while (forwarded < 16 && cyc < 400) begin
            rnd_valid = 1'($urandom_range(0, 1));
            rnd_ready = 1'($urandom_range(0, 1));
            s_axis_samp_tvalid = rnd_valid;
            m_axis_fft_tready  = rnd_ready;
            s_axis_samp_tdata  = 32'hA5A5_0000 + 32'(forwarded);
            #1;
            checkOutput("t2_tvalid_pass", 32'(m_axis_fft_tvalid), 32'(rnd_valid));
            checkOutput("t2_tready_pass", 32'(s_axis_samp_tready), 32'(rnd_ready));
            if (rnd_valid && rnd_ready) begin
                checkOutput("t2_tdata", m_axis_fft_tdata, 32'hA5A5_0000 + 32'(forwarded));
                checkOutput("t2_tlast", 32'(m_axis_fft_tlast), 32'(forwarded == 15));
                forwarded++;
            end
            cyc++;
            @(negedge aclk);
        end
        checkOutput("t2_beats", 32'(forwarded), 32'd16);
        s_axis_samp_tvalid = 1'b1;
        m_axis_fft_tready  = 1'b1;
        #1;
        checkOutput("t2_no_extra_valid", 32'(m_axis_fft_tvalid), 32'd0);
        checkOutput("t2_no_extra_ready", 32'(s_axis_samp_tready), 32'd0);
        s_axis_samp_tvalid = 1'b0;
        m_axis_fft_tready  = 1'b0;
        driveResults(16, 15);
        #1;
        checkOutput("t2_peak_bin", 32'(peak_bin), 32'd0);
        checkOutput("t2_frame_count", 32'(frame_count), 32'd1);

        // Continuous run, stop during frame 3
        $display("[TB] continuous with stop");
        doReset();
        cfg_base  = cfg_xfers;
        done_base = done_pulses;
        applyStimulus(4'd3, 1'b1, 1'b1);
        acceptCfg();
        driveSamples(8, -1);
        driveResults(8, 7);
        driveSamples(8, -1);
        driveResults(8, 7);
        driveSamples(8, 3);
        driveResults(8, 7);
        #1;
        checkOutput("t3_frame_done", 32'(frame_done), 32'd1);
        checkOutput("t3_frame_count", 32'(frame_count), 32'd3);
        @(negedge aclk);
        #1;
        checkOutput("t3_busy", 32'(busy), 32'd0);
        checkOutput("t3_cfg_xfers", 32'(cfg_xfers - cfg_base), 32'd1);
        checkOutput("t3_done_pulses", 32'(done_pulses - done_base), 32'd3);

        // Tie between two full-scale bins: lowest bin wins
        $display("[TB] tie and extreme value");
        doReset();
        res_vec[2] = {16'h0000, 16'h8000};
        res_vec[4] = {16'h0000, 16'h7FFF};
        res_vec[6] = {16'h0000, 16'h8000};
        applyStimulus(4'd3, 1'b1, 1'b0);
        acceptCfg();
        driveSamples(8, -1);
        driveResults(8, 7);
        #1;
        checkOutput("t4_peak_bin", 32'(peak_bin), 32'd2);
        checkOutput("t4_peak_mag", 32'(peak_mag), 32'h8000);

        // Early tlast, then a missing tlast, then err clears on start
        $display("[TB] bad tlast");
        doReset();
        applyStimulus(4'd3, 1'b1, 1'b0);
        acceptCfg();
        driveSamples(8, -1);
        driveResults(8, 4);
        #1;
        checkOutput("t5_early_err", 32'(err_tlast), 32'd1);
        checkOutput("t5_early_done", 32'(frame_done), 32'd1);
        @(negedge aclk);
        #1;
        checkOutput("t5_idle", 32'(busy), 32'd0);
        checkOutput("t5_sticky", 32'(err_tlast), 32'd1);
        applyStimulus(4'd3, 1'b1, 1'b0);
        #1;
        checkOutput("t5_err_cleared", 32'(err_tlast), 32'd0);
        acceptCfg();
        driveSamples(8, -1);
        driveResults(8, 99);
        #1;
        checkOutput("t5_missing_err", 32'(err_tlast), 32'd1);
        checkOutput("t5_missing_done", 32'(frame_done), 32'd1);

        // Clamp high, then reset in the middle of capture
        $display("[TB] clamp and mid-frame reset");
        doReset();
        applyStimulus(4'd15, 1'b0, 1'b0);
        #1;
        checkOutput("t6_clamp_hi", 32'(m_axis_cfg_tdata), 32'h000A);
        acceptCfg();
        s_axis_samp_tvalid = 1'b1;
        m_axis_fft_tready  = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        #1;
        checkOutput("t6_capturing", 32'(m_axis_fft_tvalid), 32'd1);
        aresetn = 1'b0;
        #1;
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        checkOutput("t6_rst_fft_tvalid", 32'(m_axis_fft_tvalid), 32'd0);
        checkOutput("t6_rst_samp_tready", 32'(s_axis_samp_tready), 32'd0);
        checkOutput("t6_rst_frame_count", 32'(frame_count), 32'd0);
        @(negedge aclk);
        clearInputs();
        aresetn = 1'b1;
        @(negedge aclk);
        applyStimulus(4'd0, 1'b1, 1'b0);
        #1;
        checkOutput("t6_clamp_lo", 32'(m_axis_cfg_tdata), 32'h0103);

        // Start and stop together: stop wins
        $display("[TB] start with stop");
        doReset();
        ctrl_stop = 1'b1;
        applyStimulus(4'd3, 1'b1, 1'b0);
        ctrl_stop = 1'b0;
        #1;
        checkOutput("t7_busy", 32'(busy), 32'd0);
        checkOutput("t7_cfg_tvalid", 32'(m_axis_cfg_tvalid), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
